// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// The helpers work on a MAX_N-wide vector; callers cast to their own N.
package mux_arb_pkg;

   localparam int MAX_N = 32;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   // First set request at or after ptr, wrapping at n; result undefined if req has no bit set.
   function automatic int rr_pick(input logic [MAX_N-1:0] req, input int ptr, input int n);
      int idx;
      rr_pick = 0;
      // Walk offsets from largest to smallest so the nearest requester wins.
      for (int k = MAX_N - 1; k >= 0; k--) begin
         if (k < n) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (req[idx]) rr_pick = idx;
         end
      end
   endfunction

   function automatic logic [MAX_N-1:0] onehot(input int idx);
      onehot = '0;
      onehot[idx] = 1'b1;
   endfunction

endpackage

// File: rtl/mux0.sv
// N:1 single-bit mux; purely combinational, no flow control.
// Select values at or beyond N yield 0.
module mux0 #(
   parameter int N     = 8,
   parameter int log2N = 3
) (
   input  logic [N-1:0]     data_in,
   input  logic [log2N-1:0] sel,
   output logic             data_out
);

   always_comb begin
      data_out = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (int'(sel) == i) data_out = data_in[i];
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing mux0 between N requesters; req to out_valid is one cycle.
// Backpressure: out_valid/data_out/gnt hold until out_ready, then ack pulses and an IDLE gap follows.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int N     = 8,
   parameter int log2N = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic [N-1:0]     data_in,
   input  logic             out_ready,
   output logic [log2N-1:0] sel,
   output logic [N-1:0]     gnt,
   output logic             out_valid,
   output logic             data_out,
   output logic [N-1:0]     ack,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [log2N-1:0] ptr_q, ptr_d;
   logic [log2N-1:0] win, sel_d;
   logic [N-1:0]     gnt_d, ack_d;
   logic             out_valid_d, data_out_d;
   logic             mux_bit;

   always_comb win = log2N'(rr_pick(MAX_N'(req), int'(ptr_q), N));

   // The mux looks at the combinational winner so the bit is captured on the grant edge.
   mux0 #(.N(N), .log2N(log2N)) u_mux0 (
      .data_in  (data_in),
      .sel      (win),
      .data_out (mux_bit)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel;
      gnt_d       = gnt;
      out_valid_d = out_valid;
      data_out_d  = data_out;
      ack_d       = '0;
      case (state_q)
         IDLE: begin
            gnt_d       = '0;
            out_valid_d = 1'b0;
            data_out_d  = 1'b0;
            if (|req) begin
               sel_d       = win;
               gnt_d       = N'(onehot(int'(win)));
               data_out_d  = mux_bit;
               out_valid_d = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (out_valid && out_ready) begin
               ack_d       = N'(onehot(int'(sel)));
               gnt_d       = '0;
               out_valid_d = 1'b0;
               data_out_d  = 1'b0;
               ptr_d       = (sel == log2N'(N - 1)) ? '0 : sel + 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         sel       <= '0;
         gnt       <= '0;
         out_valid <= 1'b0;
         data_out  <= 1'b0;
         ack       <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         sel       <= sel_d;
         gnt       <= gnt_d;
         out_valid <= out_valid_d;
         data_out  <= data_out_d;
         ack       <= ack_d;
      end
   end

   assign busy = (state_q == SEND);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: an N=8 instance plus an N=5 instance for wrap-around.
module tb_mux_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req, data_in, gnt, ack;
   logic       out_ready, out_valid, data_out, busy;
   logic [2:0] sel;

   logic [4:0] req5, data5, gnt5, ack5;
   logic       ready5, valid5, dout5, busy5;
   logic [2:0] sel5;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mux_rr_arbiter #(.N(8), .log2N(3)) dut (
      .clk(clk), .rst(rst), .req(req), .data_in(data_in), .out_ready(out_ready),
      .sel(sel), .gnt(gnt), .out_valid(out_valid), .data_out(data_out),
      .ack(ack), .busy(busy)
   );

   mux_rr_arbiter #(.N(5), .log2N(3)) dut5 (
      .clk(clk), .rst(rst), .req(req5), .data_in(data5), .out_ready(ready5),
      .sel(sel5), .gnt(gnt5), .out_valid(valid5), .data_out(dout5),
      .ack(ack5), .busy(busy5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".sel"}, 32'(sel), 32'd0);
      check({tag, ".gnt"}, 32'(gnt), 32'h00);
      check({tag, ".valid"}, 32'(out_valid), 32'd0);
      check({tag, ".dout"}, 32'(data_out), 32'd0);
      check({tag, ".ack"}, 32'(ack), 32'h00);
      check({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [7:0] dv;
      logic [7:0] pat;
      rst = 1'b1; req = '0; data_in = '0; out_ready = 1'b0;
      req5 = '0; data5 = '0; ready5 = 1'b0;
      #1;
      check_idle("reset_async");
      step();
      step();
      rst = 1'b0;
      step();
      check_idle("after_reset");

      // Single requester 4: grant next cycle, ack the cycle after.
      req = 8'h10; data_in = 8'h10; out_ready = 1'b1;
      step();
      check("single.sel", 32'(sel), 32'd4);
      check("single.gnt", 32'(gnt), 32'h10);
      check("single.valid", 32'(out_valid), 32'd1);
      check("single.dout", 32'(data_out), 32'd1);
      check("single.busy", 32'(busy), 32'd1);
      check("single.ack0", 32'(ack), 32'h00);
      req = 8'h00;
      step();
      check("single.ack", 32'(ack), 32'h10);
      check("single.valid_lo", 32'(out_valid), 32'd0);
      check("single.gnt_lo", 32'(gnt), 32'h00);
      step();
      check("single.ack_pulse", 32'(ack), 32'h00);

      // Reset in the middle of a stalled transfer; ptr was 5 before it.
      req = 8'h04; data_in = 8'h04; out_ready = 1'b0;
      step();
      check("rstmid.sel", 32'(sel), 32'd2);
      check("rstmid.valid", 32'(out_valid), 32'd1);
      step();
      rst = 1'b1;
      #1;
      check_idle("rstmid_async");
      step();
      check("rstmid.noack", 32'(ack), 32'h00);
      rst = 1'b0;
      req = 8'h81; data_in = 8'h80; out_ready = 1'b1;
      step();
      check("rstptr.sel", 32'(sel), 32'd0);
      check("rstptr.gnt", 32'(gnt), 32'h01);
      check("rstptr.dout", 32'(data_out), 32'd0);
      req = 8'h00;
      step();
      check("rstptr.ack", 32'(ack), 32'h01);

      // Fairness from ptr=0 with every requester always asking.
      rst = 1'b1;
      #1;
      rst = 1'b0;
      req = 8'hFF; data_in = 8'hA5; out_ready = 1'b1;
      for (int g = 0; g < 9; g++) begin
         pat = 8'h01 << (g % 8);
         step();
         check("rr.sel", 32'(sel), 32'(g % 8));
         check("rr.gnt", 32'(gnt), 32'(pat));
         check("rr.dout", 32'(data_out), 32'(data_in[g % 8]));
         step();
         check("rr.ack", 32'(ack), 32'(pat));
      end
      req = 8'h00;

      // Backpressure: ptr=1, only requester 0 asks; data_in changes during the stall.
      req = 8'h01; data_in = 8'h01; out_ready = 1'b0;
      step();
      check("bp.sel", 32'(sel), 32'd0);
      check("bp.valid", 32'(out_valid), 32'd1);
      check("bp.dout", 32'(data_out), 32'd1);
      data_in = 8'h00;
      for (int c = 0; c < 4; c++) begin
         step();
         check("bp.hold_valid", 32'(out_valid), 32'd1);
         check("bp.hold_dout", 32'(data_out), 32'd1);
         check("bp.hold_sel", 32'(sel), 32'd0);
         check("bp.hold_ack", 32'(ack), 32'h00);
         data_in = 8'hFE;
      end
      out_ready = 1'b1; req = 8'h00;
      step();
      check("bp.ack", 32'(ack), 32'h01);
      check("bp.valid_lo", 32'(out_valid), 32'd0);
      step();
      check("bp.ack_once", 32'(ack), 32'h00);

      // Wrap-around on the N=5 instance.
      req5 = 5'b10000; data5 = 5'b10000; ready5 = 1'b1;
      step();
      check("wrap.sel4", 32'(sel5), 32'd4);
      check("wrap.gnt4", 32'(gnt5), 32'h10);
      req5 = 5'b10001; data5 = 5'b00001;
      step();
      check("wrap.ack4", 32'(ack5), 32'h10);
      step();
      check("wrap.sel0", 32'(sel5), 32'd0);
      check("wrap.gnt0", 32'(gnt5), 32'h01);
      check("wrap.dout0", 32'(dout5), 32'd1);
      step();
      check("wrap.ack0", 32'(ack5), 32'h01);
      step();
      check("wrap.sel4b", 32'(sel5), 32'd4);
      check("wrap.dout4b", 32'(dout5), 32'd0);
      req5 = 5'b00000;
      step();
      check("wrap.ack4b", 32'(ack5), 32'h10);
      step();
      check("wrap.idle", 32'(busy5), 32'd0);

      // Every data pattern against every single-bit request.
      out_ready = 1'b1;
      for (int d = 0; d < 256; d++) begin
         dv = d[7:0];
         for (int i = 0; i < 8; i++) begin
            data_in = dv;
            req = 8'h01 << i;
            step();
            check("exh.sel", 32'(sel), 32'(i));
            check("exh.dout", 32'(data_out), 32'(dv[i]));
            req = 8'h00;
            step();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
